// File: rtl/cp0_defs_pkg.sv
// Shared CP0 definitions: exception codes, Status bit positions, vectors,
// sequencer state encoding and the EPC adjustment helper.
package cp0_defs;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_ERL   = 2;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
  localparam logic [31:0] GEN_VEC   = 32'h8000_0180;
  localparam logic [31:0] BEV_VEC   = 32'hBFC0_0380;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RET    = 2'd3;

  typedef enum logic [1:0] {
    SRC_EXC  = 2'd0,
    SRC_NMI  = 2'd1,
    SRC_ERET = 2'd2
  } src_e;

  // Delay-slot faults return to the branch; wraps modulo 2^32.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exception_ctrl_int_sync.sv
// Per-bit two-flop synchronizer for the asynchronous interrupt lines.
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg[gi] <= 1'b0;
          q[gi]        <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          q[gi]        <= meta_reg[gi];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates requests, drains the pipeline,
// captures EPC/Cause and issues commit pulses. NMI support under CP0_NMI_EN.
module cp0_exception_ctrl
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] status,
  input  logic [5:0]  hw_int,
  input  logic [1:0]  sw_int,
  input  logic        exc_req,
  input  logic [4:0]  exc_code_in,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret_req,
  input  logic        nmi_in,
  input  logic        pipe_ack,
  output logic        flush,
  output logic        exc_taken,
  output logic        eret,
  output logic        nmi,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic [31:0] epc,
  output logic [31:0] error_epc,
  output logic [31:0] vector_pc,
  output logic        vector_valid,
  output logic        busy
);

  logic [1:0]  state_reg;
  src_e        src_reg;
  logic [4:0]  code_reg;
  logic [31:0] pc_reg;
  logic        bd_reg;
  logic        exl_reg;
  logic        bev_reg;
  logic [5:0]  hw_sync;
  logic        int_pend;
  logic        int_en;
  logic        nmi_rise;
  logic [31:0] ret_vec;
  logic        commit_nmi;

  int_sync #(.W(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (hw_sync)
  );

  assign int_pend   = |({hw_sync, sw_int} & status[ST_IM_HI:ST_IM_LO]);
  assign int_en     = status[ST_IE] & ~status[ST_EXL] & ~status[ST_ERL];
  assign commit_nmi = (state_reg == S_DRAIN) && pipe_ack && (src_reg == SRC_NMI);

`ifdef CP0_NMI_EN
  logic nmi_prev_reg;

  assign nmi_rise = nmi_in & ~nmi_prev_reg;
  assign ret_vec  = status[ST_ERL] ? error_epc : epc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_prev_reg <= 1'b0;
      nmi          <= 1'b0;
      error_epc    <= 32'd0;
    end else begin
      nmi_prev_reg <= nmi_in;
      nmi          <= commit_nmi;
      if (commit_nmi)
        error_epc <= pc_reg;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{status[31:23], status[21:16], status[7:3]};
`else
  assign nmi_rise  = 1'b0;
  assign ret_vec   = epc;
  assign nmi       = 1'b0;
  assign error_epc = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{status[31:23], status[21:16], status[7:3], nmi_in, commit_nmi};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      src_reg       <= SRC_EXC;
      code_reg      <= EXC_INT;
      pc_reg        <= 32'd0;
      bd_reg        <= 1'b0;
      exl_reg       <= 1'b0;
      bev_reg       <= 1'b0;
      flush         <= 1'b0;
      exc_taken     <= 1'b0;
      eret          <= 1'b0;
      vector_valid  <= 1'b0;
      busy          <= 1'b0;
      cause_exccode <= EXC_INT;
      cause_bd      <= 1'b0;
      epc           <= 32'd0;
      vector_pc     <= RESET_VEC;
    end else begin
      exc_taken    <= 1'b0;
      eret         <= 1'b0;
      vector_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // Context is sampled every idle cycle; the value at the entry edge sticks.
          pc_reg   <= exc_pc;
          bd_reg   <= exc_bd;
          exl_reg  <= status[ST_EXL];
          bev_reg  <= status[ST_BEV];
          code_reg <= exc_req ? exc_code_in : EXC_INT;
          if (nmi_rise) begin
            src_reg   <= SRC_NMI;
            state_reg <= S_DRAIN;
            flush     <= 1'b1;
            busy      <= 1'b1;
          end else if (exc_req || (int_pend && int_en)) begin
            src_reg   <= SRC_EXC;
            state_reg <= S_DRAIN;
            flush     <= 1'b1;
            busy      <= 1'b1;
          end else if (eret_req) begin
            src_reg   <= SRC_ERET;
            state_reg <= S_RET;
            flush     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (pipe_ack) begin
            state_reg    <= S_COMMIT;
            flush        <= 1'b0;
            vector_valid <= 1'b1;
            if (src_reg == SRC_NMI) begin
              vector_pc <= RESET_VEC;
            end else begin
              exc_taken     <= 1'b1;
              cause_exccode <= code_reg;
              vector_pc     <= bev_reg ? BEV_VEC : GEN_VEC;
            end
            // Nested exceptions keep the outer handler's return context.
            if (!exl_reg) begin
              epc      <= epc_of(pc_reg, bd_reg);
              cause_bd <= bd_reg;
            end
          end
        end
        S_RET: begin
          if (pipe_ack) begin
            state_reg    <= S_COMMIT;
            flush        <= 1'b0;
            eret         <= 1'b1;
            vector_valid <= 1'b1;
            vector_pc    <= ret_vec;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
